// File: rtl/usb_line_filter_if.sv
// usb_line_filter_if: bundles the per-channel pad inputs, control strobes and conditioned outputs.
//   din        raw asynchronous channel levels (master -> filter)
//   bypass     skip the deglitch stage (master -> filter)
//   glitch_clr clear all sticky glitch flags (master -> filter)
//   dout       conditioned levels (filter -> master)
//   rise/fall  one-cycle edge pulses (filter -> master)
//   glitch     sticky abandoned-change flags (filter -> master)
interface usb_line_filter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             bypass;
    logic             glitch_clr;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] glitch;
    modport master (output din, bypass, glitch_clr, input dout, rise, fall, glitch);
    modport slave  (input din, bypass, glitch_clr, output dout, rise, fall, glitch);
endinterface

// File: rtl/usb_line_filter.sv
// usb_line_filter: per-channel synchroniser plus stable-count deglitch filter with edge pulses and sticky glitch flags.
//   clk   single rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   usb_line_filter_if slave: din/bypass/glitch_clr in, dout/rise/fall/glitch out
module usb_line_filter #(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILT_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input logic              clk,
    input logic              rst_n,
    usb_line_filter_if.slave bus
);
    localparam int            CW   = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [WIDTH-1:0] dout_q, rise_q, fall_q, glitch_q;
    logic [WIDTH-1:0] sq, diff, at_last, busy, chg, gset;

    assign sq = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VAL;
        end else begin
            sync_q[0] <= bus.din;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // A change is accepted on the edge where the counter already holds FILT_CYCLES-1
    // stable samples; a counter that is nonzero when sq falls back marks a glitch.
    always_comb begin
        at_last = '0;
        busy    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            at_last[i] = cnt_q[i] == LAST;
            busy[i]    = cnt_q[i] != '0;
        end
        diff = sq ^ dout_q;
        chg  = bus.bypass ? diff : diff & at_last;
        gset = bus.bypass ? '0 : ~diff & busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q   <= RESET_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
            glitch_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            dout_q   <= dout_q ^ chg;
            rise_q   <= chg & sq;
            fall_q   <= chg & ~sq;
            glitch_q <= gset | (glitch_q & {WIDTH{~bus.glitch_clr}});
            for (int i = 0; i < WIDTH; i++)
                cnt_q[i] <= (bus.bypass || !diff[i] || at_last[i]) ? '0 : cnt_q[i] + 1'b1;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.rise   = rise_q;
    assign bus.fall   = fall_q;
    assign bus.glitch = glitch_q;
endmodule

// File: tb/tb_usb_line_filter.sv
// tb_usb_line_filter: table-driven scoreboard bench for usb_line_filter with default parameters.
module tb_usb_line_filter;
    typedef struct {
        logic [3:0] din;
        logic       byp;
        logic       clr;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] glitch;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   row = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    usb_line_filter_if #(.WIDTH(4)) bus();

    usb_line_filter #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .FILT_CYCLES(4),
        .RESET_VAL(4'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic add(input int n, input logic [3:0] din, input logic byp, input logic clr,
                       input logic [3:0] dout, input logic [3:0] rise, input logic [3:0] fall,
                       input logic [3:0] glitch);
        vec_t v;
        v.din = din; v.byp = byp; v.clr = clr;
        v.dout = dout; v.rise = rise; v.fall = fall; v.glitch = glitch;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        bus.din = v.din;
        bus.bypass = v.byp;
        bus.glitch_clr = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("dout", bus.dout, e.dout);
        chk("rise", bus.rise, e.rise);
        chk("fall", bus.fall, e.fall);
        chk("glitch", bus.glitch, e.glitch);
        row++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"}, bus.dout, 4'h0);
        chk({tag, "_rise"}, bus.rise, 4'h0);
        chk({tag, "_fall"}, bus.fall, 4'h0);
        chk({tag, "_glitch"}, bus.glitch, 4'h0);
    endtask

    initial begin
        vec_t v;
        // level acceptance from reset with din = F, then drop to 0
        add(5, 4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'hF, 0, 0, 4'hF, 4'hF, 4'h0, 4'h0);
        add(1, 4'hF, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(5, 4'h0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 0, 0, 4'h0, 4'h0, 4'hF, 4'h0);
        add(1, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        // 3-cycle pulse on din[0] is rejected, glitch sticks until cleared
        add(3, 4'h1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(2, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(2, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h1);
        add(1, 4'h0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        // accept din[2] high, then raise din[1] and drop din[2] two cycles later
        add(5, 4'h4, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 0, 0, 4'h4, 4'h4, 4'h0, 4'h0);
        add(1, 4'h4, 0, 0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(2, 4'h6, 0, 0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(3, 4'h2, 0, 0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 0, 0, 4'h6, 4'h2, 4'h0, 4'h0);
        add(1, 4'h2, 0, 0, 4'h6, 4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 0, 0, 4'h2, 4'h0, 4'h4, 4'h0);
        add(1, 4'h2, 0, 0, 4'h2, 4'h0, 4'h0, 4'h0);
        // bypass: 1-cycle pulse on din[3] passes straight through
        add(1, 4'h2, 1, 0, 4'h2, 4'h0, 4'h0, 4'h0);
        add(1, 4'hA, 1, 0, 4'h2, 4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 1, 0, 4'h2, 4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 1, 0, 4'hA, 4'h8, 4'h0, 4'h0);
        add(1, 4'h2, 1, 0, 4'h2, 4'h0, 4'h8, 4'h0);
        add(1, 4'h2, 1, 0, 4'h2, 4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 0, 0, 4'h2, 4'h0, 4'h0, 4'h0);
        // glitch on ch0, then ch1 glitch set collides with glitch_clr
        add(1, 4'h3, 0, 0, 4'h2, 4'h0, 4'h0, 4'h0);
        add(2, 4'h2, 0, 0, 4'h2, 4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 0, 0, 4'h2, 4'h0, 4'h0, 4'h1);
        add(1, 4'h0, 0, 0, 4'h2, 4'h0, 4'h0, 4'h1);
        add(2, 4'h2, 0, 0, 4'h2, 4'h0, 4'h0, 4'h1);
        add(1, 4'h2, 0, 1, 4'h2, 4'h0, 4'h0, 4'h2);
        add(1, 4'h2, 0, 0, 4'h2, 4'h0, 4'h0, 4'h2);

        bus.din = 4'hF;
        bus.bypass = 1'b0;
        bus.glitch_clr = 1'b0;
        #2;
        chk_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // reset while ch0 counter is at 2
        v.din = 4'h3; v.byp = 0; v.clr = 0;
        v.dout = 4'h2; v.rise = 4'h0; v.fall = 4'h0; v.glitch = 4'h2;
        for (int i = 0; i < 4; i++) step(v);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v.dout = 4'h0; v.glitch = 4'h0;
        for (int i = 0; i < 5; i++) step(v);
        v.dout = 4'h3; v.rise = 4'h3;
        step(v);
        v.rise = 4'h0;
        step(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/usb_line_filter.md
# usb_line_filter

Parametrised, multi-channel input conditioner for the USB host's pad-facing inputs, such as the D+/D− receiver outputs, VBUS-valid and over-current flags. Each channel runs through a configurable-depth synchroniser, then a stable-count deglitch filter. The block emits the conditioned level, one-cycle rise/fall pulses, and a sticky glitch flag per channel. Pad buffering (`io_in` cells) sits outside this block; `din` connects directly to the pad cell outputs.

## Interface
- `WIDTH`, default 4: number of independent channels.
- `SYNC_STAGES`, default 2: synchroniser flop depth; legal range ≥ 2.
- `FILT_CYCLES`, default 4: consecutive stable cycles required to accept a new level; legal range ≥ 1.
- `RESET_VAL`, default `'0`: `WIDTH`-bit per-channel reset level for the synchroniser flops and `dout`.
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst_n` input 1: reset; asynchronous assert, active-low.
- `din` input `WIDTH`: raw, asynchronous channel inputs.
- `bypass` input 1: 1 = skip the filter, so `dout` follows the synchroniser output.
- `glitch_clr` input 1: synchronous clear of all `glitch` bits.
- `dout` output `WIDTH`: conditioned levels.
- `rise` output `WIDTH`: one-cycle pulse when a `dout` bit goes 0→1.
- `fall` output `WIDTH`: one-cycle pulse when a `dout` bit goes 1→0.
- `glitch` output `WIDTH`: sticky flag; the channel saw a candidate change that was abandoned before acceptance.

## Operation
- **Channels:** all channels are identical and fully independent.
- **Synchroniser:** a chain of `SYNC_STAGES` flops per channel. `sq` is the last stage output.
- **Counter:** `cnt` is a per-channel counter of width `$clog2(FILT_CYCLES+1)`.
- **Filter mode (`bypass` = 0), evaluated every edge per channel:**
  - If `sq == dout` and `cnt != 0`: set `glitch`, then `cnt <= 0`.
  - If `sq == dout` and `cnt == 0`: `cnt <= 0`.
  - If `sq != dout` and `cnt == FILT_CYCLES-1`: `dout <= sq`, `cnt <= 0`. On the same edge, `rise <= sq` and `fall <= ~sq`.
  - If `sq != dout` otherwise: `cnt <= cnt + 1`.
- **Bypass mode (`bypass` = 1):**
  - `dout <= sq` every edge.
  - `cnt` is held at 0.
  - `glitch` is never set.
  - `rise`/`fall` still pulse on every `dout` change.
- **Pulse width:** `rise`/`fall` bits are 0 on every edge that does not change the corresponding `dout` bit. Pulses therefore last exactly one cycle.
- **Glitch clear:** `glitch_clr` = 1 clears all `glitch` bits on the next edge. If a channel's set condition occurs on the same edge, set wins for that channel.
- **Toggling `bypass`:** the change takes effect on the next edge. A count in progress is discarded (`cnt <= 0`) and no glitch is recorded for it.
- **No FSM:** there is no state machine beyond the per-channel counter. `cnt` never exceeds `FILT_CYCLES-1`, so there is no wrap-around.

## Timing
- **Reset values (`rst_n` low, asynchronous, immediate):**
  - Synchroniser flops = `RESET_VAL`.
  - `dout` = `RESET_VAL`.
  - `cnt` = 0.
  - `rise` = `fall` = `glitch` = 0.
- **No spurious edges:** no edge pulse may occur on or after reset release unless `din` differs from `RESET_VAL`.
- **Filter latency:** `din` changes and is held stable, with edge 1 the first edge that samples the new value.
  - `sq` reflects the new value after edge `SYNC_STAGES`.
  - `dout` and the `rise`/`fall` pulse update at edge `SYNC_STAGES + FILT_CYCLES`.
  - Defaults give edge 6.
- **Bypass latency:** `SYNC_STAGES + 1` edges (defaults give edge 3).
- **Rejection:** a change whose `sq` is stable for fewer than `FILT_CYCLES` consecutive cycles is rejected. `dout` is unchanged and `glitch` is set on the edge where `sq` returns to `dout`.
- **Reset mid-count:** all state clears immediately with no pending update. After release, filtering restarts from `cnt` = 0.
- **Simultaneous changes:** changes on several channels in the same cycle are each handled independently. Pulses may coincide.

## Test plan
Parameters for all scenarios: `WIDTH`=4, `SYNC_STAGES`=2, `FILT_CYCLES`=4, `RESET_VAL`=4'h0.

- **Reset / level acceptance:** reset with `din`=4'hF, then release.
  - `dout`=0 and `rise`=0 through edge 5.
  - At edge 6, `dout`=4'hF and `rise`=4'hF for one cycle.
  - `glitch`=0 throughout.
- **Glitch rejection:** drive `din[0]` high for 3 cycles, then low.
  - `dout[0]` stays 0 and `rise[0]` never pulses.
  - `glitch[0]`=1 and stays set.
  - A `glitch_clr` pulse → `glitch`=0 on the next edge.
- **Channel independence:** raise `din[1]`, then drop `din[2]` 2 cycles later (with `din[2]` previously accepted high).
  - `rise[1]` pulses at edge 6 and `fall[2]` pulses 2 edges later.
  - No other bits toggle.
- **Bypass:** `bypass`=1, apply a 1-cycle high pulse on `din[3]`.
  - `dout[3]`=1 for exactly one cycle at edge 3.
  - `rise[3]` pulses at edge 3 and `fall[3]` pulses at edge 4.
  - `glitch[3]`=0.
- **Reset mid-count:** raise `din[0]`, then assert `rst_n` low when `cnt[0]`=2.
  - All outputs read 0 before the next edge.
  - After release with `din[0]` still high, `dout[0]` rises at edge 6.
- **Set/clear collision:** assert `glitch_clr` on the same edge that a glitch set fires on channel 1.
  - `glitch[1]`=1.
  - Other channels clear to 0.
